// File: rtl/prf_free_list_banked_pkg.sv
// core_types_pkg
// Core-wide sizing constants shared by the rename free list and its banks.
// PR_COUNT, PRF_BANK_COUNT and AR_COUNT are powers of two. PRF_BANK_COUNT
// divides both PR_COUNT and AR_COUNT.
package core_types_pkg;

    localparam int PR_COUNT                 = 128;
    localparam int LOG_PR_COUNT             = $clog2(PR_COUNT);
    localparam int PRF_BANK_COUNT           = 4;
    localparam int LOG_PRF_BANK_COUNT       = $clog2(PRF_BANK_COUNT);
    localparam int AR_COUNT                 = 32;
    localparam int LOG_AR_COUNT             = $clog2(AR_COUNT);
    localparam int FREE_LIST_BANK_DEPTH     = PR_COUNT / PRF_BANK_COUNT;
    localparam int LOG_FREE_LIST_BANK_DEPTH = $clog2(FREE_LIST_BANK_DEPTH);

endpackage

// File: rtl/prf_free_list_banked_free_list_bank.sv
// free_list_bank
// One bank of the PR free list. This is a circular FIFO of DEPTH tags. Every tag
// whose low bits equal BANK_ID belongs to this bank.
// The reset image holds INIT_COUNT tags. They run AR_COUNT+BANK_ID upward in
// strides of PRF_BANK_COUNT.
// Ports:
//   CLK, nRST      clock; asynchronous active-low reset
//   i_enq_valid    a freed tag is returned this cycle
//   i_enq_tag      the freed tag
//   i_deq          consume the head tag (ignored while empty)
//   o_head_tag     tag at the head
//   o_empty        no tag available
//   o_count_next   occupancy after this cycle's enq/deq
//   o_err          enqueue rejected (bank full or tag of another bank)
module free_list_bank
    import core_types_pkg::*;
#(
    parameter int DEPTH      = FREE_LIST_BANK_DEPTH,
    parameter int TAG_W      = LOG_PR_COUNT,
    parameter int BANK_ID    = 0,
    parameter int INIT_COUNT = FREE_LIST_BANK_DEPTH - AR_COUNT / PRF_BANK_COUNT
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     i_enq_valid,
    input  logic [TAG_W-1:0]         i_enq_tag,
    input  logic                     i_deq,
    output logic [TAG_W-1:0]         o_head_tag,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count_next,
    output logic                     o_err
);
    localparam int LD = $clog2(DEPTH);
    localparam int LB = LOG_PRF_BANK_COUNT;

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [LD:0]      r_head;
    logic [LD:0]      r_tail;
    logic             w_full;
    logic             w_bank_ok;
    logic             w_enq_ok;
    logic             w_deq_ok;
    logic [LD:0]      w_head_next;
    logic [LD:0]      w_tail_next;

    function automatic logic [TAG_W-1:0] init_tag(input int k);
        return TAG_W'(AR_COUNT + k * PRF_BANK_COUNT + BANK_ID);
    endfunction

    // Pointers carry one extra wrap bit.
    // Equal pointers mean empty. Equal index bits with different wrap bits mean full.
    assign o_empty   = (r_head == r_tail);
    assign w_full    = (r_head[LD-1:0] == r_tail[LD-1:0]) && (r_head[LD] != r_tail[LD]);
    assign w_bank_ok = (i_enq_tag[LB-1:0] == LB'(BANK_ID));

    // Full is judged on pre-edge state, so a same-cycle dequeue does not make room.
    assign w_enq_ok  = i_enq_valid && !w_full && w_bank_ok;
    assign o_err     = i_enq_valid && (w_full || !w_bank_ok);
    assign w_deq_ok  = i_deq && !o_empty;

    assign w_head_next  = r_head + (LD+1)'(w_deq_ok);
    assign w_tail_next  = r_tail + (LD+1)'(w_enq_ok);
    assign o_count_next = w_tail_next - w_head_next;
    assign o_head_tag   = r_mem[r_head[LD-1:0]];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= (k < INIT_COUNT) ? init_tag(k) : '0;
            end
            r_head <= '0;
            r_tail <= (LD+1)'(INIT_COUNT);
        end else begin
            if (w_enq_ok) begin
                r_mem[r_tail[LD-1:0]] <= i_enq_tag;
            end
            r_head <= w_head_next;
            r_tail <= w_tail_next;
        end
    end

endmodule

// File: rtl/prf_free_list_banked.sv
// prf_free_list_banked
// This is the banked free list of physical register tags for rename. There is one
// FIFO per PRF bank.
// Deq lane i is served by bank (rr+i) mod B. rr rotates on every cycle that
// consumes at least one tag, which spreads allocations over the banks' write ports.
// Ports:
//   CLK, nRST            clock; asynchronous active-low reset
//   enq_valid_by_bank    freed tag returned to bank b
//   enq_PR_by_bank       freed tag for bank b (low bits must equal b)
//   deq_valid_by_lane    lane i offers a tag
//   deq_PR_by_lane       tag offered on lane i
//   deq_ready_by_lane    lane i consumes its tag
//   free_count           total free tags
//   overflow_err         sticky: enqueue into a full bank or wrong-bank tag
module prf_free_list_banked
    import core_types_pkg::*;
(
    input  logic                                          CLK,
    input  logic                                          nRST,
    input  logic [PRF_BANK_COUNT-1:0]                     enq_valid_by_bank,
    input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   enq_PR_by_bank,
    output logic [PRF_BANK_COUNT-1:0]                     deq_valid_by_lane,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   deq_PR_by_lane,
    input  logic [PRF_BANK_COUNT-1:0]                     deq_ready_by_lane,
    output logic [LOG_PR_COUNT:0]                         free_count,
    output logic                                          overflow_err
);
    localparam int B  = PRF_BANK_COUNT;
    localparam int LB = LOG_PRF_BANK_COUNT;
    localparam int D  = FREE_LIST_BANK_DEPTH;
    localparam int LD = LOG_FREE_LIST_BANK_DEPTH;
    localparam int LP = LOG_PR_COUNT;

    logic [LB-1:0]          r_rr;
    logic [LP:0]            r_free_count;
    logic                   r_overflow;
    logic [B-1:0]           w_bank_empty;
    logic [B-1:0]           w_bank_deq;
    logic [B-1:0]           w_bank_err;
    logic [B-1:0]           w_lane_fire;
    logic [B-1:0][LP-1:0]   w_bank_head;
    logic [B-1:0][LD:0]     w_bank_count_next;
    logic [LP:0]            w_count_sum;

    for (genvar b = 0; b < B; b++) begin : g_bank
        free_list_bank #(
            .DEPTH      (D),
            .TAG_W      (LP),
            .BANK_ID    (b),
            .INIT_COUNT (D - AR_COUNT / B)
        ) u_bank (
            .CLK          (CLK),
            .nRST         (nRST),
            .i_enq_valid  (enq_valid_by_bank[b]),
            .i_enq_tag    (enq_PR_by_bank[b]),
            .i_deq        (w_bank_deq[b]),
            .o_head_tag   (w_bank_head[b]),
            .o_empty      (w_bank_empty[b]),
            .o_count_next (w_bank_count_next[b]),
            .o_err        (w_bank_err[b])
        );
    end

    // Bank to lane. This path depends only on registered state.
    always_comb begin
        deq_valid_by_lane = '0;
        deq_PR_by_lane    = '0;
        for (int i = 0; i < B; i++) begin
            deq_valid_by_lane[i] = ~w_bank_empty[r_rr + LB'(i)];
            deq_PR_by_lane[i]    = w_bank_head[r_rr + LB'(i)];
        end
    end

    assign w_lane_fire = deq_ready_by_lane & deq_valid_by_lane;

    // Lane to bank. Bank b is served by lane (b - rr) mod B.
    always_comb begin
        w_bank_deq = '0;
        for (int b = 0; b < B; b++) begin
            w_bank_deq[b] = w_lane_fire[LB'(b) - r_rr];
        end
    end

    // Summing the next-state occupancies keeps the registered total in step with the banks.
    always_comb begin
        w_count_sum = '0;
        for (int b = 0; b < B; b++) begin
            w_count_sum = w_count_sum + {{(LP-LD){1'b0}}, w_bank_count_next[b]};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr         <= '0;
            r_free_count <= (LP+1)'(PR_COUNT - AR_COUNT);
            r_overflow   <= 1'b0;
        end else begin
            if (|w_lane_fire) begin
                r_rr <= r_rr + 1'b1;
            end
            r_free_count <= w_count_sum;
            r_overflow   <= r_overflow | (|w_bank_err);
        end
    end

    assign free_count   = r_free_count;
    assign overflow_err = r_overflow;

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (nRST && |(deq_ready_by_lane & ~deq_valid_by_lane)) begin
            $warning("prf_free_list_banked: ready on a lane with no tag, ignored");
        end
    end
`endif

endmodule

// File: tb/tb_prf_free_list_banked.sv
module tb_prf_free_list_banked;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [3:0]      enq_valid;
    logic [3:0][6:0] enq_PR;
    logic [3:0]      deq_valid;
    logic [3:0][6:0] deq_PR;
    logic [3:0]      deq_ready;
    logic [7:0]      free_count;
    logic            overflow_err;

    int n_tests = 0;
    int n_fail  = 0;
    int rr      = 0;
    int seen [128];

    prf_free_list_banked dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .enq_valid_by_bank (enq_valid),
        .enq_PR_by_bank    (enq_PR),
        .deq_valid_by_lane (deq_valid),
        .deq_PR_by_lane    (deq_PR),
        .deq_ready_by_lane (deq_ready),
        .free_count        (free_count),
        .overflow_err      (overflow_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        enq_valid = '0;
        enq_PR    = '0;
        deq_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int lane;
        int exp_b1 [5];
        exp_b1 = '{37, 45, 49, 53, 41};
        nRST = 1'b0;
        idle();
        for (int t = 0; t < 128; t++) seen[t] = 0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        step();

        // 1: reset image
        chk("rst_valid", deq_valid, 4'hF);
        for (int i = 0; i < 4; i++) chk("rst_lane_pr", deq_PR[i], 32 + i);
        chk("rst_free_count", free_count, 96);
        chk("rst_overflow", overflow_err, 0);

        // 2: allocate all 96 tags; lane0 walks bank0,1,2,3,...
        for (int c = 0; c < 24; c++) begin
            chk("alloc_lane0_vld", deq_valid[0], 1);
            chk("alloc_lane0_pr", deq_PR[0], 32 + 4 * c + (c % 4));
            for (int i = 0; i < 4; i++) if (deq_valid[i]) seen[deq_PR[i]]++;
            deq_ready = 4'hF;
            step();
            rr = (rr + 1) % 4;
        end
        bad = 0;
        for (int t = 0; t < 128; t++) begin
            if ((t < 32 && seen[t] != 0) || (t >= 32 && seen[t] != 1)) bad++;
        end
        chk("alloc_unique_tags", bad, 0);
        chk("drained_valid", deq_valid, 4'h0);
        chk("drained_free_count", free_count, 0);
        step();  // ready still high with nothing valid
        idle();
        chk("extra_ready_free_count", free_count, 0);
        chk("extra_ready_overflow", overflow_err, 0);
        chk("extra_ready_valid", deq_valid, 4'h0);

        // 3: return tag 8 into empty bank0 (rr is 0 -> lane0)
        enq_valid = 4'b0001;
        enq_PR[0] = 7'd8;
        #1;
        chk("no_bypass_valid", deq_valid[0], 0);
        step();
        idle();
        chk("ret_valid", deq_valid, 4'b0001);
        chk("ret_pr", deq_PR[0], 8);
        chk("ret_free_count", free_count, 1);

        // 4: bank1 gets 33,37,45,49,53; then deq head while enqueuing 41
        for (int k = 0; k < 5; k++) begin
            enq_valid = 4'b0010;
            enq_PR[1] = 7'(k == 0 ? 33 : (k == 1 ? 37 : 45 + 4 * (k - 2)));
            step();
        end
        idle();
        chk("b1_fill_free_count", free_count, 6);
        lane = (1 - rr) & 3;
        chk("b1_head_pr", deq_PR[lane], 33);
        deq_ready[lane] = 1'b1;
        enq_valid = 4'b0010;
        enq_PR[1] = 7'd41;
        step();
        idle();
        rr = (rr + 1) % 4;
        chk("b1_same_cycle_free_count", free_count, 6);
        for (int k = 0; k < 5; k++) begin
            lane = (1 - rr) & 3;
            chk("b1_drain_pr", deq_PR[lane], exp_b1[k]);
            deq_ready[lane] = 1'b1;
            step();
            idle();
            rr = (rr + 1) % 4;
        end
        chk("b1_drained_free_count", free_count, 1);
        chk("b1_no_err_yet", overflow_err, 0);

        // 5: wrong-bank tag, then overflow of a full bank
        enq_valid = 4'b0010;
        enq_PR[1] = 7'd6;
        step();
        idle();
        chk("wrong_bank_err", overflow_err, 1);
        chk("wrong_bank_free_count", free_count, 1);
        for (int k = 0; k < 32; k++) begin
            enq_valid = 4'b0100;
            enq_PR[2] = 7'(2 + 4 * k);
            step();
        end
        idle();
        chk("b2_full_free_count", free_count, 33);
        enq_valid = 4'b0100;
        enq_PR[2] = 7'd2;
        step();
        idle();
        chk("full_enq_dropped", free_count, 33);
        chk("full_enq_err", overflow_err, 1);
        lane = (2 - rr) & 3;
        chk("b2_head_pr", deq_PR[lane], 2);
        deq_ready[lane] = 1'b1;
        enq_valid = 4'b0100;
        enq_PR[2] = 7'd2;
        step();
        idle();
        rr = (rr + 1) % 4;
        chk("full_deq_enq_free_count", free_count, 32);
        chk("full_deq_enq_next_head", deq_PR[(2 - rr) & 3], 6);

        // 6: asynchronous reset in the middle of a burst
        deq_ready = 4'hF;
        enq_valid = 4'b0001;
        enq_PR[0] = 7'd12;
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_valid", deq_valid, 4'hF);
        chk("async_rst_lane0", deq_PR[0], 32);
        chk("async_rst_lane3", deq_PR[3], 35);
        chk("async_rst_free_count", free_count, 96);
        chk("async_rst_overflow", overflow_err, 0);
        idle();
        @(negedge CLK);
        nRST = 1'b1;
        step();
        chk("post_rst_lane1", deq_PR[1], 33);
        chk("post_rst_free_count", free_count, 96);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
